fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, buffers returned
//  words with their PC, and presents them to the IF/OF boundary. Consumes the branch unit's
//  redirect (EX_branchPC, EX_is_Branch_Taken): redirects the PC and squashes wrong-path fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  FIFO_DEPTH  4              fetch-buffer entries (power of 2, >=2)
//  MAX_OUTST   4              max imem requests in flight (<= FIFO_DEPTH)
// PORTS
//  clk                 in   1   single clock, rising edge
//  reset_n             in   1   asynchronous, active-low reset
//  EX_is_Branch_Taken  in   1   redirect request from branch unit
//  EX_branchPC         in   32  redirect target
//  IF_stall            in   1   hazard stall: hold IF/OF output, do not pop buffer
//  imem_req_valid      out  1   fetch request valid
//  imem_req_addr       out  32  fetch address (= PC)
//  imem_req_ready      in   1   imem accepts request when valid&&ready
//  imem_rsp_valid      in   1   returned word valid (in-order, >=1 cycle after accept)
//  imem_rsp_data       in   32  returned instruction
//  IF_OF_valid         out  1   IF/OF latch holds a valid instruction
//  IF_OF_PC            out  32  PC of latched instruction
//  IF_OF_IR            out  32  latched instruction (NOP_INSTR when !IF_OF_valid)
// BEHAVIOUR
//  Reset (async, reset_n=0): PC=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RUN,
//   imem_req_valid=0, IF_OF_valid=0, IF_OF_PC=0, IF_OF_IR=NOP_INSTR. Reset mid-operation
//   discards everything; responses arriving after release are ignored until a new request.
//  Request: imem_req_valid = (state==RUN) && !EX_is_Branch_Taken && outstanding<MAX_OUTST &&
//   (fifo_count+outstanding)<FIFO_DEPTH. On accept, PC<=PC+4, outstanding++. Never overflows FIFO.
//  Response: in RUN, push {pc_q, data} where pc_q is the PC recorded at accept (in-order tag
//   queue inside FIFO path); outstanding--. In DRAIN, drop response, outstanding--, drop--.
//  Output latch: when !IF_stall, IF_OF <= FIFO head (pop) if non-empty, else IF_OF_valid<=0,
//   IR<=NOP_INSTR. When IF_stall, latch and FIFO head hold. Fetch-to-output latency: 1 cycle
//   after response if FIFO was empty and no stall (response may not bypass FIFO in same cycle).
//  Redirect (EX_is_Branch_Taken=1), priority over IF_stall and all else, same edge:
//   PC<=EX_branchPC; FIFO flushed; IF_OF_valid<=0, IR<=NOP_INSTR; no request issued this cycle;
//   drop<=outstanding-(rsp_valid?1:0); a response arriving this cycle is discarded.
//   state<=DRAIN if resulting drop>0 else RUN.
//  FSM: RUN -> DRAIN on redirect with in-flight requests; DRAIN -> RUN when drop reaches 0
//   (the dropping response's cycle); redirect while in DRAIN: reload PC, recompute drop, stay.
//  Arithmetic: PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0). Counters sized $clog2(DEPTH+1).
//  Boundaries: FIFO full -> no request; push and pop same cycle allowed at full/empty;
//   rsp_valid with outstanding==0 is a protocol error (assert in sim, ignore in RTL).
// STRUCTURE
//  Package cpu_pkg: NOP_INSTR, XLEN=32, fetch_state_t {RUN, DRAIN}.
//  Sub-module fetch_fifo (sync FIFO, width 64 = {pc,ir}, DEPTH param, push/pop/flush/count).
//  Request-PC tag queue shares fetch_fifo type (width 32, depth MAX_OUTST).
// TESTING
//  Reset, imem ready=1, 1-cycle latency -> addrs 0,4,8,... ; IF_OF_PC 0,4,8 back-to-back valid.
//  IF_stall=1 for 5 cycles -> IF_OF held, FIFO fills to 4, imem_req_valid drops; resumes in order.
//  Branch to 0x100 with 2 in flight -> both responses dropped, DRAIN 2 cycles, next IF_OF_PC=0x100.
//  Branch and rsp_valid same cycle, plus branch during DRAIN -> no stale word ever reaches IF_OF.
//  RESET_PC=0xFFFF_FFF8 -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
//  reset_n pulsed low mid-stream -> outputs at reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_pkg;

    localparam int XLEN = 32;

    // Canonical no-op (addi x0, x0, 0) presented whenever the IF/OF latch is empty.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // RUN: normal fetching. DRAIN: swallowing responses to wrong-path requests.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used both for the fetch buffer {pc, ir} and for the
// request-PC tag queue. Push and pop in the same cycle are allowed at full
// and at empty boundaries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with explicit wrap so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? {AW{1'b0}} : p + 1'b1;
    endfunction

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checker for the instruction-memory response channel.
module fetch_unit_checker #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset_n,
    input logic          rsp_valid,
    input logic [CW-1:0] outstanding
);

    // A returned word with nothing in flight means the memory side misbehaved.
    property p_rsp_has_request;
        @(posedge clk) disable iff (!reset_n)
            rsp_valid |-> (outstanding != {CW{1'b0}});
    endproperty

    a_rsp_has_request: assert property (p_rsp_has_request);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, tags
// each request with its PC, buffers returned words and drives the IF/OF latch.
// A taken branch redirects the PC, flushes the buffer and drains the
// responses still in flight for the abandoned path.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUTST  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        EX_is_Branch_Taken,
    input  logic [31:0] EX_branchPC,
    input  logic        IF_stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        IF_OF_valid,
    output logic [31:0] IF_OF_PC,
    output logic [31:0] IF_OF_IR
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTST + 1);
    localparam int SW  = FCW + 1;

    fetch_state_t   state_r;
    fetch_state_t   state_next_s;
    logic [31:0]    pc_r;
    logic [31:0]    pc_next_s;
    logic [OCW-1:0] drop_r;
    logic [OCW-1:0] drop_next_s;

    // The tag queue holds one entry per request in flight, so its count is
    // the outstanding-request counter.
    logic [OCW-1:0] outst_s;
    logic [31:0]    tag_head_s;
    logic [FCW-1:0] fifo_count_s;
    logic [63:0]    fifo_head_s;
    logic [SW-1:0]  occ_s;

    logic           req_valid_s;
    logic           accept_s;
    logic           rsp_fire_s;
    logic           fifo_push_s;
    logic           fifo_pop_s;

    // Request gating: reserve a buffer slot for every request in flight so
    // the fetch buffer can never overflow.
    always_comb begin
        occ_s       = SW'(fifo_count_s) + SW'(outst_s);
        req_valid_s = reset_n && (state_r == RUN) && !EX_is_Branch_Taken &&
                      (outst_s < OCW'(MAX_OUTST)) && (occ_s < SW'(FIFO_DEPTH));
        accept_s    = req_valid_s && imem_req_ready;
        rsp_fire_s  = imem_rsp_valid && (outst_s != {OCW{1'b0}});
        fifo_push_s = rsp_fire_s && (state_r == RUN) && !EX_is_Branch_Taken;
        fifo_pop_s  = !IF_stall && !EX_is_Branch_Taken && (fifo_count_s != {FCW{1'b0}});
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTST)
    ) u_tag_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .push      (accept_s),
        .push_data (pc_r),
        .pop       (rsp_fire_s),
        .head      (tag_head_s),
        .count     (outst_s)
    );

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (EX_is_Branch_Taken),
        .push      (fifo_push_s),
        .push_data ({tag_head_s, imem_rsp_data}),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s)
    );

    // Next PC, drain count and fetch state; a redirect overrides everything.
    always_comb begin
        state_next_s = state_r;
        drop_next_s  = drop_r;
        pc_next_s    = pc_r;
        if (EX_is_Branch_Taken) begin
            pc_next_s    = EX_branchPC;
            drop_next_s  = outst_s - OCW'(rsp_fire_s);
            state_next_s = (drop_next_s != {OCW{1'b0}}) ? DRAIN : RUN;
        end else begin
            pc_next_s = accept_s ? pc_step(pc_r) : pc_r;
            case (state_r)
                RUN: begin
                    state_next_s = RUN;
                end
                DRAIN: begin
                    if (rsp_fire_s && (drop_r != {OCW{1'b0}})) begin
                        drop_next_s  = drop_r - OCW'(1'b1);
                        state_next_s = (drop_r == OCW'(1'b1)) ? RUN : DRAIN;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end
                default: begin
                    state_next_s = RUN;
                    drop_next_s  = {OCW{1'b0}};
                end
            endcase
        end
    end

    // State, PC and drain-count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RUN;
            pc_r    <= RESET_PC;
            drop_r  <= {OCW{1'b0}};
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            drop_r  <= drop_next_s;
        end
    end

    // IF/OF latch: cleared on redirect, held on stall, otherwise loads the buffer head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            IF_OF_valid <= 1'b0;
            IF_OF_PC    <= 32'h0000_0000;
            IF_OF_IR    <= NOP_INSTR;
        end else if (EX_is_Branch_Taken) begin
            IF_OF_valid <= 1'b0;
            IF_OF_PC    <= IF_OF_PC;
            IF_OF_IR    <= NOP_INSTR;
        end else if (IF_stall) begin
            IF_OF_valid <= IF_OF_valid;
            IF_OF_PC    <= IF_OF_PC;
            IF_OF_IR    <= IF_OF_IR;
        end else if (fifo_count_s != {FCW{1'b0}}) begin
            IF_OF_valid <= 1'b1;
            IF_OF_PC    <= fifo_head_s[63:32];
            IF_OF_IR    <= fifo_head_s[31:0];
        end else begin
            IF_OF_valid <= 1'b0;
            IF_OF_PC    <= IF_OF_PC;
            IF_OF_IR    <= NOP_INSTR;
        end
    end

endmodule
